// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared state type and default widths for the pulse-train generator
package pulse_gen_pkg;
   localparam int DEF_CNT_W = 6;
   localparam int DEF_LEN_W = 4;
   typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} pg_state_t;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter that flags expiry when it reaches zero
module phase_timer #(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [LEN_W-1:0] load_val,
   output logic             expire
);
   logic [LEN_W-1:0] val;
   // load a new phase length or count down, holding at zero
   always_ff @(posedge clk) begin
      if (rst) val <= '0;
      else if (load) val <= load_val;
      else if (val != '0) val <= val - LEN_W'(1);
   end
   assign expire = val == '0;
endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits a programmed number of high pulses with programmable high/low widths
module pulse_train_gen
   import pulse_gen_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] count_in,
   input  logic [LEN_W-1:0] high_len,
   input  logic [LEN_W-1:0] low_len,
   output logic             a,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] remaining
);
   pg_state_t state, nxt;
   logic [LEN_W-1:0] hl, ll, load_val;
   logic load, expire, accept;

   // timer reload value for a programmed length; zero length behaves as one cycle
   function automatic logic [LEN_W-1:0] eff(input logic [LEN_W-1:0] v);
      return (v == '0) ? '0 : v - LEN_W'(1);
   endfunction

   assign accept = state == IDLE && start;

   phase_timer #(.LEN_W(LEN_W)) u_timer (
      .clk(clk),
      .rst(rst),
      .load(load),
      .load_val(load_val),
      .expire(expire)
   );

   // next state and phase-timer reload; stop takes priority over phase end
   always_comb begin
      nxt = state;
      load = 1'b0;
      load_val = hl;
      unique case (state)
         IDLE: if (start) begin
            load = 1'b1;
            load_val = eff(high_len);
            nxt = (count_in == '0) ? DONE : HIGH;
         end
         HIGH: if (stop) nxt = IDLE;
         else if (expire) begin
            nxt = (remaining == CNT_W'(1)) ? DONE : LOW;
            load = 1'b1;
            load_val = ll;
         end
         LOW: if (stop) nxt = IDLE;
         else if (expire) begin
            nxt = HIGH;
            load = 1'b1;
            load_val = hl;
         end
         DONE: nxt = IDLE;
      endcase
   end

   // state, registered outputs, parameter latches and pulses-remaining count
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         remaining <= '0;
         hl <= '0;
         ll <= '0;
      end else begin
         state <= nxt;
         a <= nxt == HIGH;
         busy <= nxt == HIGH || nxt == LOW;
         done <= nxt == DONE;
         if (accept) begin
            hl <= eff(high_len);
            ll <= eff(low_len);
            remaining <= count_in;
         end else if (state == HIGH && !stop && expire && remaining != '0)
            remaining <= remaining - CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: random and directed trains checked against a per-cycle expected-output queue
module tb_pulse_train_gen;
   import pulse_gen_pkg::*;
   localparam int CW = DEF_CNT_W;
   localparam int LW = DEF_LEN_W;

   logic clk = 1'b0;
   logic rst, start, stop;
   logic [CW-1:0] count_in;
   logic [LW-1:0] high_len, low_len;
   logic a, busy, done;
   logic [CW-1:0] remaining;

   typedef struct packed {
      logic a;
      logic busy;
      logic done;
      logic [CW-1:0] rem;
   } exp_t;

   exp_t cur;
   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int rises = 0;
   logic a_d = 1'b0;

   always #5 clk = ~clk;

   pulse_train_gen dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .stop(stop),
      .count_in(count_in),
      .high_len(high_len),
      .low_len(low_len),
      .a(a),
      .busy(busy),
      .done(done),
      .remaining(remaining)
   );

   always @(negedge clk) begin
      if (a === 1'b1 && a_d !== 1'b1) rises++;
      a_d = a;
   end

   task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
      end
   endtask

   function automatic exp_t mk(logic ea, logic eb, logic ed, int er);
      exp_t e;
      e.a = ea;
      e.busy = eb;
      e.done = ed;
      e.rem = CW'(er);
      return e;
   endfunction

   // whole train laid out cycle by cycle: C pulses of H high, L low between them, then a done cycle
   task automatic build(int c, int h, int l);
      int hh = (h == 0) ? 1 : h;
      int ll = (l == 0) ? 1 : l;
      for (int k = 1; k <= c; k++) begin
         repeat (hh) q.push_back(mk(1, 1, 0, c - k + 1));
         if (k < c) repeat (ll) q.push_back(mk(0, 1, 0, c - k));
      end
      q.push_back(mk(0, 0, 1, 0));
   endtask

   task automatic step(logic r, logic s, logic p, int c, int h, int l);
      rst = r;
      start = s;
      stop = p;
      count_in = CW'(c);
      high_len = LW'(h);
      low_len = LW'(l);
      if (r) begin
         cur = '0;
         q.delete();
      end else if (cur.busy && p) begin
         cur.a = 0;
         cur.busy = 0;
         cur.done = 0;
         q.delete();
      end else if (q.size() > 0) cur = q.pop_front();
      else if (!cur.busy && !cur.done && s) begin
         build(c, h, l);
         cur = q.pop_front();
      end else begin
         cur.a = 0;
         cur.busy = 0;
         cur.done = 0;
      end
      @(negedge clk);
      chk("a", 32'(a), 32'(cur.a));
      chk("busy", 32'(busy), 32'(cur.busy));
      chk("done", 32'(done), 32'(cur.done));
      chk("remaining", 32'(remaining), 32'(cur.rem));
   endtask

   task automatic idle(int n);
      repeat (n) step(0, 0, 0, $urandom_range(63), $urandom_range(15), $urandom_range(15));
   endtask

   initial begin
      int r0;
      cur = '0;
      rst = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      count_in = '0;
      high_len = '0;
      low_len = '0;
      @(negedge clk);
      step(1, 1, 0, 5, 1, 1);
      step(1, 0, 0, 0, 0, 0);
      idle(2);
      step(0, 1, 0, 3, 1, 1);
      idle(8);
      step(0, 1, 0, 2, 0, 3);
      idle(8);
      step(0, 1, 0, 0, 2, 2);
      idle(3);
      step(0, 1, 0, 10, 2, 2);
      idle(12);
      step(0, 0, 1, 10, 2, 2);
      chk("stop_rem", 32'(remaining), 32'd7);
      idle(4);
      step(0, 1, 0, 10, 2, 2);
      step(0, 1, 0, 5, 1, 1);
      step(0, 1, 0, 5, 1, 1);
      step(1, 0, 0, 0, 0, 0);
      idle(3);
      r0 = rises;
      step(0, 1, 0, 37, 1, 1);
      idle(80);
      chk("loop_rises", 32'(rises - r0), 32'd37);
      repeat (3000)
         step($urandom_range(199) == 0, $urandom_range(3) == 0, $urandom_range(29) == 0,
              $urandom_range(12), $urandom_range(4), $urandom_range(4));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
